// File: rtl/seq_logic_unit.sv
// seq_logic_unit: multi-cycle bitwise logic unit (AND/OR/XOR/NOR).
// Processes SLICE bits per clock, LSB slice first, over WIDTH-bit operands.
//
// Handshake: start is sampled only while idle (busy=0); the accepting edge
// latches A, B and op. busy stays high until the edge that processes the last
// slice, and that same edge updates result and raises done for one cycle.
// start while busy is dropped, never queued.
//
// state_dbg mirrors the FSM state for checkers: 0 = IDLE, 1 = BUSY.
module seq_logic_unit #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             state_dbg
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]    LAST_K = CW'(N - 1);
    localparam logic [WIDTH-1:0] SMASK  = WIDTH'({SLICE{1'b1}});

    // Reject configurations that cannot be split into whole slices.
    generate
        if ((WIDTH % SLICE) != 0) begin : g_bad_slice
            $error("seq_logic_unit: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [SLICE-1:0] sa;
    logic [SLICE-1:0] sb;
    logic [SLICE-1:0] sr;
    int               idx;
    logic             last;
    logic             accept;

    assign last   = (cnt == LAST_K);
    assign accept = (state == IDLE) && start;

    // State register; reset aborts any operation immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: leave IDLE on start, return after the final slice.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BUSY;
            BUSY:    if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy      = 1'b0;
        state_dbg = 1'b0;
        if (state == BUSY) begin
            busy      = 1'b1;
            state_dbg = 1'b1;
        end
    end

    // Slice k of the latched operands, gated by the latched op.
    always_comb begin
        idx  = int'(cnt) * SLICE;
        a_sh = a_q >> idx;
        b_sh = b_q >> idx;
        sa   = a_sh[SLICE-1:0];
        sb   = b_sh[SLICE-1:0];
        sr   = '0;
        case (op_q)
            2'b00:   sr = sa & sb;
            2'b01:   sr = sa | sb;
            2'b10:   sr = sa ^ sb;
            2'b11:   sr = ~(sa | sb);
            default: sr = '0;
        endcase
        // Splice the new slice into the accumulator; the final slice's
        // spliced value is what gets copied to result.
        acc_nxt = (acc & ~(SMASK << idx)) | (WIDTH'(sr) << idx);
    end

    // Datapath: operand latch, slice counter, accumulator, result and done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            cnt    <= '0;
            acc    <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_q  <= A;
                b_q  <= B;
                op_q <= op;
                cnt  <= '0;
                acc  <= '0;
            end else if (state == BUSY) begin
                acc <= acc_nxt;
                if (last) begin
                    cnt    <= '0;
                    result <= acc_nxt;
                    done   <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Zero flag follows the registered result.
    assign zero = (result == '0);

endmodule

// File: tb/tb_seq_logic_unit.sv
// Testbench for seq_logic_unit: main 32/8 instance with directed and random
// operations, plus 32/32 (single slice) and 16/4 instances.
module tb_seq_logic_unit;

    localparam int NM = 4;  // slices in the 32/8 instance

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        start_m = 1'b0;
    logic [1:0]  op_m = '0;
    logic [31:0] a_m = '0, b_m = '0;
    logic        busy_m, done_m, zero_m, st_m;
    logic [31:0] result_m;

    logic        start_s = 1'b0;
    logic [1:0]  op_s = '0;
    logic [31:0] a_s = '0, b_s = '0;
    logic        busy_s, done_s, zero_s, st_s;
    logic [31:0] result_s;

    logic        start_w = 1'b0;
    logic [1:0]  op_w = '0;
    logic [15:0] a_w = '0, b_w = '0;
    logic        busy_w, done_w, zero_w, st_w;
    logic [15:0] result_w;

    seq_logic_unit #(.WIDTH(32), .SLICE(8)) dut_m (
        .clk(clk), .reset(reset), .start(start_m), .op(op_m), .A(a_m), .B(b_m),
        .busy(busy_m), .done(done_m), .result(result_m), .zero(zero_m), .state_dbg(st_m)
    );

    seq_logic_unit #(.WIDTH(32), .SLICE(32)) dut_s (
        .clk(clk), .reset(reset), .start(start_s), .op(op_s), .A(a_s), .B(b_s),
        .busy(busy_s), .done(done_s), .result(result_s), .zero(zero_s), .state_dbg(st_s)
    );

    seq_logic_unit #(.WIDTH(16), .SLICE(4)) dut_w (
        .clk(clk), .reset(reset), .start(start_w), .op(op_w), .A(a_w), .B(b_w),
        .busy(busy_w), .done(done_w), .result(result_w), .zero(zero_w), .state_dbg(st_w)
    );

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word result of the selected operation.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        case (o)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation on the 32/8 instance. With noise set, operands, op and
    // start are scrambled while busy and must not disturb the result.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit noise);
        logic [31:0] got;
        op_m = o; a_m = a; b_m = b; start_m = 1'b1;
        tick();                                   // E0 accepts
        exp_q.push_back(exp);
        check("busy_e0", busy_m, 1);
        start_m = 1'b0;
        for (int k = 1; k < NM; k++) begin        // E1..E(N-1)
            if (noise) begin
                a_m = $urandom; b_m = $urandom;
                op_m = 2'($urandom_range(0, 3));
                start_m = 1'($urandom_range(0, 1));
            end
            tick();
            check("busy_mid", busy_m, 1);
            check("done_mid", done_m, 0);
            check("result_hold", result_m, last_res);
        end
        start_m = 1'b0;
        tick();                                   // EN completes
        got = exp_q.pop_front();
        check("done_en", done_m, 1);
        check("busy_en", busy_m, 0);
        check("result_en", result_m, got);
        check("zero_en", zero_m, (got == 0) ? 1 : 0);
        last_res = got;
        tick();                                   // E(N+1)
        check("done_clear", done_m, 0);
        check("busy_after", busy_m, 0);
        check("result_after", result_m, last_res);
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        logic [31:0] s1a, s1b, s2a, s2b, e1, e2;
        logic [1:0]  o1, o2;

        #2;
        check("rst_busy", busy_m, 0);
        check("rst_done", done_m, 0);
        check("rst_result", result_m, 0);
        check("rst_zero", zero_m, 1);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Directed vectors
        run_op(2'b01, 32'hF0F00000, 32'h00000F0F, 32'hF0F00F0F, 1'b0);
        run_op(2'b00, 32'h12345678, 32'h0F0F0F0F, 32'h02040608, 1'b0);
        run_op(2'b10, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0);
        run_op(2'b11, 32'hFFFF0000, 32'h0000FF00, 32'h000000FF, 1'b0);
        run_op(2'b00, 32'hAAAAAAAA, 32'h55555555, 32'h00000000, 1'b0);
        // Operands/op/start disturbed during busy
        run_op(2'b01, 32'h00FF00FF, 32'h0F000F00, 32'h0FFF0FFF, 1'b1);

        // Random operations against the model
        for (int i = 0; i < 16; i++) begin
            logic [31:0] ra, rb;
            logic [1:0]  ro;
            ra = $urandom; rb = $urandom; ro = 2'($urandom_range(0, 3));
            run_op(ro, ra, rb, model(ro, ra, rb), 1'b1);
        end

        // Back-to-back with start held high
        s1a = $urandom; s1b = $urandom; o1 = 2'($urandom_range(0, 3));
        s2a = $urandom; s2b = $urandom; o2 = 2'($urandom_range(0, 3));
        e1 = model(o1, s1a, s1b);
        e2 = model(o2, s2a, s2b);
        op_m = o1; a_m = s1a; b_m = s1b; start_m = 1'b1;
        tick();
        exp_q.push_back(e1);
        op_m = o2; a_m = s2a; b_m = s2b;
        for (int k = 1; k < NM; k++) begin
            tick();
            check("b2b_busy1", busy_m, 1);
            check("b2b_done1_low", done_m, 0);
        end
        tick();
        check("b2b_done1", done_m, 1);
        check("b2b_idle", busy_m, 0);
        check("b2b_result1", result_m, exp_q.pop_front());
        tick();                                   // second accept
        exp_q.push_back(e2);
        check("b2b_done1_clear", done_m, 0);
        check("b2b_busy2", busy_m, 1);
        check("b2b_result1_hold", result_m, e1);
        start_m = 1'b0;
        for (int k = 1; k < NM; k++) begin
            tick();
            check("b2b_busy2_mid", busy_m, 1);
        end
        tick();
        check("b2b_done2", done_m, 1);
        check("b2b_result2", result_m, exp_q.pop_front());
        last_res = e2;
        tick();
        check("b2b_done2_clear", done_m, 0);

        // Make result nonzero, then reset mid-operation
        run_op(2'b01, 32'h80000001, 32'h00000000, 32'h80000001, 1'b0);
        op_m = 2'b10; a_m = 32'h1234ABCD; b_m = 32'h0; start_m = 1'b1;
        tick();                                   // E0
        exp_q.push_back(32'h1234ABCD);
        start_m = 1'b0;
        tick();                                   // E1
        tick();                                   // E2
        reset = 1'b1;
        #1;
        check("arst_busy", busy_m, 0);
        check("arst_done", done_m, 0);
        check("arst_result", result_m, 0);
        check("arst_zero", zero_m, 1);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        last_res = '0;
        for (int k = 0; k < 2 * NM; k++) begin
            tick();
            check("arst_no_done", done_m, 0);
            check("arst_idle", busy_m, 0);
        end
        run_op(2'b00, 32'hFFFF00FF, 32'h0F0F0F0F, 32'h0F0F000F, 1'b0);

        // Single-slice instance: OR completes one edge after acceptance
        op_s = 2'b01; a_s = 32'h0000FFFF; b_s = 32'hFFFF0000; start_s = 1'b1;
        tick();
        start_s = 1'b0;
        check("n1_busy", busy_s, 1);
        check("n1_done_low", done_s, 0);
        tick();
        check("n1_done", done_s, 1);
        check("n1_busy_low", busy_s, 0);
        check("n1_result", result_s, 32'hFFFFFFFF);
        check("n1_zero", zero_s, 0);
        tick();
        check("n1_done_clear", done_s, 0);

        // 16/4 instance: nonzero result first, then XOR to zero
        op_w = 2'b10; a_w = 16'hFFFF; b_w = 16'h00F0; start_w = 1'b1;
        tick();
        start_w = 1'b0;
        for (int k = 1; k < 4; k++) begin
            tick();
            check("w_done_low", done_w, 0);
        end
        tick();
        check("w_done1", done_w, 1);
        check("w_result1", {16'h0, result_w}, 32'h0000FF0F);
        tick();
        op_w = 2'b10; a_w = 16'hFFFF; b_w = 16'hFFFF; start_w = 1'b1;
        tick();
        start_w = 1'b0;
        check("w_busy", busy_w, 1);
        for (int k = 1; k < 4; k++) begin
            tick();
            check("w_hold", {16'h0, result_w}, 32'h0000FF0F);
        end
        tick();
        check("w_done2", done_w, 1);
        check("w_result2", {16'h0, result_w}, 32'h0);
        check("w_zero", zero_w, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
